// File: rtl/stream_sync_pkg.sv
// Shared definitions for the stream_sync pipeline stages.
//   - default widths for the sensor stream and the statistics counters
//   - frame gate state encoding
package stream_sync_pkg;

  localparam int unsigned DefSensorDatWidth = 10;
  localparam int unsigned DefChannelNum     = 4;
  localparam int unsigned DefRegWd          = 32;
  localparam int unsigned DefLineCntWd      = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StPass = 2'd2,
    StSkip = 2'd3
  } gate_state_e;

endpackage

// File: rtl/stream_frame_gate_stat.sv
// Frame statistics for stream_frame_gate.
//   clk_i, rst_ni    : pixel clock, asynchronous active-low reset
//   pass_start_i     : strobe, a forwarded frame begins this cycle
//   pass_end_i       : strobe, a forwarded frame ends this cycle
//   skip_end_i       : strobe, a dropped frame ends this cycle
//   pass_next_i      : level, the gate forwards in the coming cycle
//   lval_i           : line valid already qualified by frame valid
//   frame_cnt_o      : forwarded frames (wraps)
//   drop_cnt_o       : dropped frames (wraps)
//   last_line_cnt_o  : line count of the last forwarded frame
module stream_frame_gate_stat #(
  parameter int unsigned RegWd     = 32,
  parameter int unsigned LineCntWd = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 pass_start_i,
  input  logic                 pass_end_i,
  input  logic                 skip_end_i,
  input  logic                 pass_next_i,
  input  logic                 lval_i,
  output logic [RegWd-1:0]     frame_cnt_o,
  output logic [RegWd-1:0]     drop_cnt_o,
  output logic [LineCntWd-1:0] last_line_cnt_o
);

  logic                 lval_q;
  logic                 lval_rise;
  logic [LineCntWd-1:0] line_cnt_q, line_cnt_d;
  logic [RegWd-1:0]     frame_cnt_q, drop_cnt_q;
  logic [LineCntWd-1:0] last_line_cnt_q;

  assign lval_rise = lval_i & ~lval_q;

  // Clear on frame entry first, so a line starting together with the frame still counts.
  always_comb begin
    line_cnt_d = line_cnt_q;
    if (pass_start_i) begin
      line_cnt_d = '0;
    end
    if (pass_next_i && lval_rise && (line_cnt_d != '1)) begin
      line_cnt_d = line_cnt_d + LineCntWd'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lval_q          <= 1'b0;
      line_cnt_q      <= '0;
      frame_cnt_q     <= '0;
      drop_cnt_q      <= '0;
      last_line_cnt_q <= '0;
    end else begin
      lval_q     <= lval_i;
      line_cnt_q <= line_cnt_d;
      if (pass_end_i) begin
        frame_cnt_q     <= frame_cnt_q + RegWd'(1);
        last_line_cnt_q <= line_cnt_q;
      end
      if (skip_end_i) begin
        drop_cnt_q <= drop_cnt_q + RegWd'(1);
      end
    end
  end

  assign frame_cnt_o     = frame_cnt_q;
  assign drop_cnt_o      = drop_cnt_q;
  assign last_line_cnt_o = last_line_cnt_q;

endmodule

// File: rtl/stream_frame_gate.sv
// Whole-frame gate for the sync_buffer pixel stream.
// Stream enable and acquisition start take effect only at a frame-valid rising edge, so
// downstream logic only ever sees complete frames. Output is the input delayed by one clock.
//   clk_pix, reset_pix_n      : pixel clock, asynchronous active-low reset
//   i_fval/i_lval/iv_pix_data : stream from sync_buffer
//   i_stream_enable           : stream enable (clk_pix domain)
//   i_acquisition_start       : acquisition start (clk_pix domain)
//   o_fval/o_lval/ov_pix_data : gated stream
//   o_frame_active            : a forwarded frame is in progress
//   ov_frame_cnt/ov_drop_cnt  : forwarded / dropped frame counters
//   ov_last_line_cnt          : line count of the last forwarded frame
module stream_frame_gate
  import stream_sync_pkg::*;
#(
  parameter int unsigned SENSOR_DAT_WIDTH = DefSensorDatWidth,
  parameter int unsigned CHANNEL_NUM      = DefChannelNum,
  parameter int unsigned REG_WD           = DefRegWd,
  parameter int unsigned LINE_CNT_WD      = DefLineCntWd
) (
  input  logic                                  clk_pix,
  input  logic                                  reset_pix_n,
  input  logic                                  i_fval,
  input  logic                                  i_lval,
  input  logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
  input  logic                                  i_stream_enable,
  input  logic                                  i_acquisition_start,
  output logic                                  o_fval,
  output logic                                  o_lval,
  output logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic                                  o_frame_active,
  output logic [REG_WD-1:0]                     ov_frame_cnt,
  output logic [REG_WD-1:0]                     ov_drop_cnt,
  output logic [LINE_CNT_WD-1:0]                ov_last_line_cnt
);

  gate_state_e state_q, state_d;
  logic        fval_q;
  logic        fval_rise;
  logic        en;
  logic        pass_next;
  logic        lval_in_frame;
  logic        lval_fwd;
  logic        pass_start;
  logic        pass_end;
  logic        skip_end;

  assign fval_rise     = i_fval & ~fval_q;
  assign en            = i_stream_enable & i_acquisition_start;
  assign lval_in_frame = i_lval & i_fval;

  // IDLE waits for a low frame valid so a frame already running at reset release is discarded.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (!i_fval) state_d = StWait;
      StWait:  if (fval_rise) state_d = en ? StPass : StSkip;
      StPass:  if (!i_fval) state_d = StWait;
      StSkip:  if (!i_fval) state_d = StWait;
      default: state_d = StIdle;
    endcase
  end

  assign pass_next  = (state_d == StPass);
  assign pass_start = (state_q != StPass) && pass_next;
  assign pass_end   = (state_q == StPass) && !i_fval;
  assign skip_end   = (state_q == StSkip) && !i_fval;
  assign lval_fwd   = lval_in_frame & pass_next;

  // fval_q resets high so a frame valid held across reset is not seen as a rising edge.
  always_ff @(posedge clk_pix or negedge reset_pix_n) begin
    if (!reset_pix_n) begin
      state_q        <= StIdle;
      fval_q         <= 1'b1;
      o_fval         <= 1'b0;
      o_lval         <= 1'b0;
      ov_pix_data    <= '0;
      o_frame_active <= 1'b0;
    end else begin
      state_q        <= state_d;
      fval_q         <= i_fval;
      o_fval         <= i_fval & pass_next;
      o_lval         <= lval_fwd;
      ov_pix_data    <= lval_fwd ? iv_pix_data : '0;
      o_frame_active <= pass_next;
    end
  end

  stream_frame_gate_stat #(
    .RegWd     (REG_WD),
    .LineCntWd (LINE_CNT_WD)
  ) u_stat (
    .clk_i           (clk_pix),
    .rst_ni          (reset_pix_n),
    .pass_start_i    (pass_start),
    .pass_end_i      (pass_end),
    .skip_end_i      (skip_end),
    .pass_next_i     (pass_next),
    .lval_i          (lval_in_frame),
    .frame_cnt_o     (ov_frame_cnt),
    .drop_cnt_o      (ov_drop_cnt),
    .last_line_cnt_o (ov_last_line_cnt)
  );

endmodule

// File: tb/tb_stream_frame_gate.sv
module tb_stream_frame_gate;

  localparam int unsigned DW = 10;
  localparam int unsigned CN = 4;
  localparam int unsigned RW = 32;
  localparam int unsigned LW = 16;
  localparam int unsigned PW = DW * CN;

  logic          clk_pix = 1'b0;
  logic          reset_pix_n = 1'b0;
  logic          i_fval = 1'b0;
  logic          i_lval = 1'b0;
  logic [PW-1:0] iv_pix_data = '0;
  logic          i_stream_enable = 1'b0;
  logic          i_acquisition_start = 1'b0;
  logic          o_fval, o_lval, o_frame_active;
  logic [PW-1:0] ov_pix_data;
  logic [RW-1:0] ov_frame_cnt, ov_drop_cnt;
  logic [LW-1:0] ov_last_line_cnt;

  int          n_tests = 0;
  int          n_fail = 0;
  bit          se_v, acq_v, rnd_en;
  int          en_timer;
  int unsigned exp_frames, exp_drops, exp_last;

  always #5 clk_pix = ~clk_pix;

  stream_frame_gate #(
    .SENSOR_DAT_WIDTH (DW),
    .CHANNEL_NUM      (CN),
    .REG_WD           (RW),
    .LINE_CNT_WD      (LW)
  ) dut (
    .clk_pix             (clk_pix),
    .reset_pix_n         (reset_pix_n),
    .i_fval              (i_fval),
    .i_lval              (i_lval),
    .iv_pix_data         (iv_pix_data),
    .i_stream_enable     (i_stream_enable),
    .i_acquisition_start (i_acquisition_start),
    .o_fval              (o_fval),
    .o_lval              (o_lval),
    .ov_pix_data         (ov_pix_data),
    .o_frame_active      (o_frame_active),
    .ov_frame_cnt        (ov_frame_cnt),
    .ov_drop_cnt         (ov_drop_cnt),
    .ov_last_line_cnt    (ov_last_line_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    chk({tag, " frame_cnt"}, 64'(ov_frame_cnt), 64'(exp_frames));
    chk({tag, " drop_cnt"}, 64'(ov_drop_cnt), 64'(exp_drops));
    chk({tag, " last_line_cnt"}, 64'(ov_last_line_cnt), 64'(exp_last));
  endtask

  // Drive one clock of input, then check the registered output one edge later.
  // fwd says whether the frame this cycle belongs to must be forwarded.
  task automatic cycle(input bit f, input bit l, input bit fwd);
    logic [PW-1:0] d;
    bit            on;
    d                   = PW'({$urandom, $urandom});
    i_fval              = f;
    i_lval              = l;
    iv_pix_data         = d;
    i_stream_enable     = se_v;
    i_acquisition_start = acq_v;
    on                  = fwd & f;
    @(posedge clk_pix);
    #1;
    chk("stream", {o_fval, o_lval, o_frame_active, ov_pix_data},
        {on, on & l, on, d & {PW{on & l}}});
    if (rnd_en) begin
      en_timer--;
      if (en_timer <= 0) begin
        if ($urandom_range(1, 0) == 1) se_v = !se_v;
        else acq_v = !acq_v;
        en_timer = $urandom_range(300, 10);
      end
    end
  endtask

  task automatic gap(input int n, input int flip_at);
    for (int t = 0; t < n; t++) begin
      if (t == flip_at) se_v = !se_v;
      cycle(1'b0, 1'($urandom_range(1, 0)), 1'b0);
    end
  endtask

  // One frame: lead cycles, nlines lines of llen clocks separated by lgap, then lgap+trail.
  // flip_at toggles stream enable at that frame cycle; rst_on/rst_off assert/release reset
  // at the start of those lines.
  task automatic frame(input int nlines, input int llen, input int lgap, input int lead,
                       input int trail, input int flip_at, input int rst_on, input int rst_off);
    bit fwd;
    bit counted;
    int per;
    int total;
    fwd     = 1'b0;
    counted = 1'b1;
    per     = llen + lgap;
    total   = lead + nlines * per + trail;
    for (int t = 0; t < total; t++) begin
      int ln;
      int w;
      bit l;
      ln = (t >= lead) ? (t - lead) / per : -1;
      w  = (t >= lead) ? (t - lead) % per : -1;
      l  = (ln >= 0) && (ln < nlines) && (w < llen);
      if (t == flip_at) se_v = !se_v;
      if (t == 0) fwd = se_v & acq_v;
      if (rst_on >= 0 && ln == rst_on && w == 0) begin
        reset_pix_n = 1'b0;
        fwd         = 1'b0;
        counted     = 1'b0;
        exp_frames  = 0;
        exp_drops   = 0;
        exp_last    = 0;
        #1;
        chk("reset immediate stream", {o_fval, o_lval, o_frame_active, ov_pix_data}, 64'd0);
        check_counts("reset immediate");
      end
      if (rst_off >= 0 && ln == rst_off && w == 0) reset_pix_n = 1'b1;
      cycle(1'b1, l, fwd);
    end
    if (counted) begin
      if (fwd) begin
        exp_frames++;
        exp_last = nlines;
      end else begin
        exp_drops++;
      end
    end
  endtask

  initial begin
    int unsigned base;
    se_v       = 1'b1;
    acq_v      = 1'b1;
    rnd_en     = 1'b0;
    en_timer   = 0;
    exp_frames = 0;
    exp_drops  = 0;
    exp_last   = 0;

    // Reset with a frame already running; the rest of that frame must be discarded.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
    check_counts("reset");
    reset_pix_n = 1'b1;
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'(i % 3 == 0), 1'b0);
    gap(10, -1);
    check_counts("idle discard");

    // 1: continuous enable, five 64x64 frames.
    for (int k = 0; k < 5; k++) begin
      frame(64, 64, 4, 2, 2, -1, -1, -1);
      gap(8, -1);
    end
    check_counts("t1");
    chk("t1 frames", 64'(ov_frame_cnt), 64'd5);
    chk("t1 lines", 64'(ov_last_line_cnt), 64'd64);

    // 2: enable drops 10 clk into frame 2 and returns 10 clk after its end.
    frame(8, 16, 4, 2, 2, -1, -1, -1);
    gap(20, -1);
    frame(8, 16, 4, 2, 2, 10, -1, -1);
    gap(20, 10);
    frame(6, 12, 3, 2, 2, -1, -1, -1);
    gap(6, -1);
    frame(5, 10, 3, 2, 2, -1, -1, -1);
    gap(6, -1);
    check_counts("t2");
    chk("t2 frames", 64'(ov_frame_cnt), 64'd9);
    // Enable falls in the very cycle of the rise: frame dropped.
    frame(4, 8, 2, 1, 1, 0, -1, -1);
    gap(5, 0);
    check_counts("t2 rise edge");
    chk("t2 drops", 64'(ov_drop_cnt), 64'd1);

    // 3: enable comes up mid-frame; that frame is dropped whole.
    se_v = 1'b0;
    frame(6, 16, 4, 2, 2, 20, -1, -1);
    gap(10, -1);
    frame(6, 16, 4, 2, 2, -1, -1, -1);
    gap(4, -1);
    frame(7, 9, 4, 2, 2, -1, -1, -1);
    gap(4, -1);
    acq_v = 1'b0;
    frame(3, 9, 4, 2, 2, -1, -1, -1);
    gap(4, -1);
    acq_v = 1'b1;
    check_counts("t3");
    chk("t3 drops", 64'(ov_drop_cnt), 64'd3);

    // 4: 1-clk frame, one-cycle gap, 3-clk frame; no lines.
    frame(0, 1, 1, 1, 0, -1, -1, -1);
    gap(1, -1);
    frame(0, 1, 1, 3, 0, -1, -1, -1);
    gap(5, -1);
    check_counts("t4");
    chk("t4 frames", 64'(ov_frame_cnt), 64'd13);
    chk("t4 lines", 64'(ov_last_line_cnt), 64'd0);

    // 5: reset at line 30, released at line 40.
    frame(64, 64, 4, 2, 2, -1, 30, 40);
    gap(10, -1);
    check_counts("t5 after reset");
    frame(8, 16, 4, 2, 2, -1, -1, -1);
    gap(10, -1);
    check_counts("t5");
    chk("t5 frames", 64'(ov_frame_cnt), 64'd1);

    // 6: random enable churn over 30 frames.
    base     = ov_frame_cnt + ov_drop_cnt;
    rnd_en   = 1'b1;
    en_timer = $urandom_range(300, 10);
    for (int k = 0; k < 30; k++) begin
      frame($urandom_range(6, 2), $urandom_range(40, 8), $urandom_range(6, 2),
            $urandom_range(4, 1), $urandom_range(4, 1), -1, -1, -1);
      gap($urandom_range(20, 1), -1);
    end
    rnd_en = 1'b0;
    check_counts("t6");
    chk("t6 total", 64'(ov_frame_cnt + ov_drop_cnt - base), 64'd30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
